// File: rtl/tile_seq_ctrl.sv
// Per-tile sequencer for the edge-detection datapath: load, process,
// stream the output tile, then clear and re-arm for the next tile.
module tile_seq_ctrl #(
    parameter int LOAD_LEN = 80,
    parameter int OUT_DIM  = 18,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_end,
    output logic             proc_start,
    input  logic             proc_done,
    input  logic             out_ready,
    output logic             readable,
    output logic [4:0]       out_row,
    output logic [4:0]       out_col,
    output logic [8:0]       out_addr,
    output logic             out_last,
    input  logic             abort,
    output logic             tile_clear,
    output logic [CNT_W-1:0] tile_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROC,
        OUT,
        CLEAR
    } state_t;

    localparam logic [6:0] LOAD_LAST = 7'(LOAD_LEN - 1);
    localparam logic [4:0] DIM_LAST  = 5'(OUT_DIM - 1);
    localparam logic [8:0] ADDR_LAST = 9'(OUT_DIM * OUT_DIM - 1);

    state_t     state;
    state_t     state_n;
    logic [6:0] load_cnt;
    logic       load_beat;
    logic       out_beat;
    logic       aborted_q;
    logic       abort_ok;

    assign abort_ok = abort && (state == LOAD || state == PROC || state == OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        in_ready   = 1'b0;
        load_end   = 1'b0;
        readable   = 1'b0;
        tile_clear = 1'b0;
        load_beat  = 1'b0;
        out_beat   = 1'b0;
        out_last   = (state == OUT) && (out_addr == ADDR_LAST);
        unique case (state)
            IDLE: begin
                state_n = LOAD;
            end
            LOAD: begin
                in_ready  = 1'b1;
                load_end  = (load_cnt == LOAD_LAST);
                load_beat = in_valid;
                if (abort) begin
                    state_n = CLEAR;
                end else if (in_valid && load_end) begin
                    state_n = PROC;
                end
            end
            PROC: begin
                load_end = 1'b1;
                if (abort) begin
                    state_n = CLEAR;
                end else if (proc_done) begin
                    state_n = OUT;
                end
            end
            OUT: begin
                readable = 1'b1;
                load_end = 1'b1;
                out_beat = out_ready;
                if (abort || (out_ready && out_last)) begin
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                tile_clear = 1'b1;
                state_n    = LOAD;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Counters are zeroed on the way into CLEAR so the clear cycle shows index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_addr   <= '0;
            tile_cnt   <= '0;
            proc_start <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            proc_start <= (state == LOAD) && (state_n == PROC);
            aborted_q  <= abort_ok;
            if (state == CLEAR && !aborted_q) begin
                tile_cnt <= tile_cnt + CNT_W'(1);
            end
            if (state_n == CLEAR) begin
                load_cnt <= '0;
                out_row  <= '0;
                out_col  <= '0;
                out_addr <= '0;
            end else begin
                if (load_beat) begin
                    load_cnt <= load_end ? 7'd0 : load_cnt + 7'd1;
                end
                if (state == PROC && state_n == OUT) begin
                    out_row  <= '0;
                    out_col  <= '0;
                    out_addr <= '0;
                end
                if (out_beat) begin
                    if (out_col == DIM_LAST) begin
                        out_col <= '0;
                        out_row <= out_row + 5'd1;
                    end else begin
                        out_col <= out_col + 5'd1;
                    end
                    out_addr <= out_addr + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Scoreboard bench for tile_seq_ctrl: randomized tiles, backpressure,
// abort and mid-tile asynchronous reset against a tile-level model.
module tb_tile_seq_ctrl;

    localparam int LOAD_LEN = 80;
    localparam int OUT_DIM  = 18;
    localparam int CNT_W    = 16;
    localparam int BEATS    = OUT_DIM * OUT_DIM;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             load_end;
    logic             proc_start;
    logic             proc_done = 1'b0;
    logic             out_ready = 1'b0;
    logic             readable;
    logic [4:0]       out_row;
    logic [4:0]       out_col;
    logic [8:0]       out_addr;
    logic             out_last;
    logic             abort = 1'b0;
    logic             tile_clear;
    logic [CNT_W-1:0] tile_cnt;

    tile_seq_ctrl #(
        .LOAD_LEN(LOAD_LEN),
        .OUT_DIM (OUT_DIM),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load_end  (load_end),
        .proc_start(proc_start),
        .proc_done (proc_done),
        .out_ready (out_ready),
        .readable  (readable),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .abort     (abort),
        .tile_clear(tile_clear),
        .tile_cnt  (tile_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int addr;
        int last;
    } beat_t;

    typedef struct {
        int cnt;
        bit aborted;
    } clr_t;

    beat_t out_q[$];
    clr_t  clr_q[$];

    int vectors = 0;
    int errors  = 0;
    int exp_tiles = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    int    mon_loaded = 0;
    bit    ps_exp = 0;
    bit    clr_pend = 0;
    int    pend_cnt = 0;
    beat_t eb;
    clr_t  ec;

    always @(negedge clk) begin
        if (reset) begin
            mon_loaded = 0;
            ps_exp     = 0;
            clr_pend   = 0;
        end else begin
            if (clr_pend) begin
                chk("tile_cnt", int'(tile_cnt), pend_cnt);
                chk("in_ready_after_clear", int'(in_ready), 1);
                clr_pend = 0;
            end
            if (proc_start || ps_exp) begin
                chk("proc_start", int'(proc_start), int'(ps_exp));
            end
            ps_exp = 0;
            if (in_ready) begin
                chk("load_end_in_load", int'(load_end), int'(mon_loaded == LOAD_LEN - 1));
                if (in_valid) begin
                    mon_loaded++;
                    if (mon_loaded == LOAD_LEN) begin
                        ps_exp     = 1;
                        mon_loaded = 0;
                    end
                end
            end
            if (readable) begin
                if (out_q.size() == 0) begin
                    chk("readable_unexpected", 1, 0);
                end else begin
                    eb = out_q[0];
                    chk("out_row", int'(out_row), eb.row);
                    chk("out_col", int'(out_col), eb.col);
                    chk("out_addr", int'(out_addr), eb.addr);
                    chk("out_last", int'(out_last), eb.last);
                    chk("load_end_in_out", int'(load_end), 1);
                    if (out_ready) void'(out_q.pop_front());
                end
            end
            if (tile_clear) begin
                if (clr_q.size() == 0) begin
                    chk("tile_clear_unexpected", 1, 0);
                end else begin
                    ec = clr_q.pop_front();
                    chk("clear_addr", int'(out_addr), 0);
                    chk("clear_row", int'(out_row), 0);
                    chk("clear_col", int'(out_col), 0);
                    chk("clear_load_end", int'(load_end), 0);
                    if (ec.aborted) out_q.delete();
                    else chk("out_q_drained", out_q.size(), 0);
                    pend_cnt = ec.cnt;
                    clr_pend = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: drop every 3rd cycle, 2: random
    task automatic do_load(input int mode);
        int acc = 0;
        int cyc = 0;
        while (acc < LOAD_LEN) begin
            case (mode)
                1:       in_valid = ((cyc % 3) != 2);
                2:       in_valid = ($urandom_range(0, 3) != 0);
                default: in_valid = 1'b1;
            endcase
            if (in_ready && in_valid) acc++;
            step();
            cyc++;
            if (cyc > 2000) begin
                chk("load_timeout", acc, LOAD_LEN);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_proc_out(input bit rnd, input int stall_at, input int abort_at);
        int n = 0;
        int beats = 0;
        int stall = 0;
        int cyc = 0;
        while (!proc_start && n < 50) begin
            step();
            n++;
        end
        if (!proc_start) chk("proc_start_timeout", 0, 1);
        repeat (rnd ? $urandom_range(0, 6) : 5) step();
        for (int a = 0; a < BEATS; a++) begin
            out_q.push_back('{a / OUT_DIM, a % OUT_DIM, a, int'(a == BEATS - 1)});
        end
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        chk("readable_after_done", int'(readable), 1);
        while (beats < BEATS) begin
            if (beats == abort_at) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                clr_q.push_back('{exp_tiles, 1'b1});
                step();
                abort     = 1'b0;
                out_ready = 1'b0;
                break;
            end
            if (beats == stall_at && stall < 4) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (readable && out_ready) begin
                beats++;
                if (beats == BEATS) begin
                    exp_tiles++;
                    clr_q.push_back('{exp_tiles, 1'b0});
                end
            end
            step();
            cyc++;
            if (cyc > 3000) begin
                chk("out_timeout", beats, BEATS);
                break;
            end
        end
        out_ready = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #2;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_load_end", int'(load_end), 0);
        chk("rst_proc_start", int'(proc_start), 0);
        chk("rst_readable", int'(readable), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_tile_clear", int'(tile_clear), 0);
        chk("rst_tile_cnt", int'(tile_cnt), 0);
        step();
        step();
        reset = 1'b0;

        do_load(0);
        do_proc_out(1'b0, -1, -1);
        do_load(1);
        do_proc_out(1'b0, 17, -1);
        do_load(2);
        do_proc_out(1'b1, -1, -1);
        do_load(2);
        do_proc_out(1'b0, -1, 100);
        do_load(2);
        do_proc_out(1'b1, -1, -1);

        do_load(2);
        repeat (2) step();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_load_end", int'(load_end), 0);
        chk("arst_proc_start", int'(proc_start), 0);
        chk("arst_readable", int'(readable), 0);
        chk("arst_out_last", int'(out_last), 0);
        chk("arst_tile_clear", int'(tile_clear), 0);
        chk("arst_tile_cnt", int'(tile_cnt), 0);
        exp_tiles = 0;
        step();
        step();
        reset = 1'b0;
        do_load(0);
        do_proc_out(1'b1, -1, -1);

        chk("clr_q_empty", clr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tile_seq_ctrl.md
Name: tile_seq_ctrl

Overview:
- Per-tile sequencer for the edge-detection datapath in CHIP.
- Accepts 80 five-pixel input columns (LOAD_LEN), then raises load_end and launches processing.
- Streams 18x18 = 324 output edge positions with readable and row/col/address indices.
- Issues a one-cycle tile_clear and re-arms for the next tile; this replaces the per-tile external reset pulse.

Parameters:
- LOAD_LEN, 80: input beats per tile.
- OUT_DIM, 18: output tile edge length; output beats = OUT_DIM*OUT_DIM.
- CNT_W, 16: width of the tile counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  datapath input column present this cycle.
- in_ready  output  1  controller accepts an input beat.
- load_end  output  1  last input beat is being presented, or the tile is past load.
- proc_start  output  1  one-cycle pulse that starts datapath processing.
- proc_done  input  1  one-cycle pulse: datapath has finished the tile.
- out_ready  input  1  downstream consumer accepts an output beat.
- readable  output  1  edge_out is valid at out_addr.
- out_row  output  5  output row index, 0..OUT_DIM-1.
- out_col  output  5  output column index, 0..OUT_DIM-1.
- out_addr  output  9  linear output index, row*OUT_DIM+col.
- out_last  output  1  readable and out_addr == OUT_DIM*OUT_DIM-1.
- abort  input  1  synchronous tile abort.
- tile_clear  output  1  one-cycle pulse that clears datapath tile state.
- tile_cnt  output  CNT_W  number of tiles completed; wraps.

Behaviour:
- Reset values: state=IDLE; all counters 0; in_ready, load_end, proc_start, readable, out_last and tile_clear all 0.
- States: IDLE, LOAD, PROC, OUT, CLEAR.
- IDLE: in_ready=0. Moves to LOAD on the next cycle, unconditionally.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid=1; each accepted beat increments load_cnt (7 bits).
  - load_end=1 combinationally while load_cnt==LOAD_LEN-1.
  - Acceptance of the beat with load_cnt==LOAD_LEN-1 moves the FSM to PROC; load_cnt clears to 0.
  - If in_valid=0, hold state and count; no timeout.
- PROC:
  - in_ready=0; load_end=1.
  - proc_start=1 in the first PROC cycle only.
  - proc_done is sampled in every PROC cycle, including the first. When proc_done=1, move to OUT with row=col=addr=0.
- OUT:
  - readable=1; load_end=1.
  - An output beat advances only when out_ready=1.
  - Advance order: col+1; on col==OUT_DIM-1, col=0 and row+1; addr+1 on every advance.
  - An accepted beat with out_last=1 moves the FSM to CLEAR.
  - With out_ready=0, all indices hold stable.
- CLEAR:
  - tile_clear=1 for exactly one cycle; tile_cnt+1, wrapping at 2^CNT_W.
  - Indices reset to 0; next state is LOAD.
  - load_end=0 from this cycle on.
- abort=1 in LOAD, PROC or OUT:
  - The next state is CLEAR; tile_cnt is NOT incremented on an aborted tile.
  - Counters zero in CLEAR as normal.
  - abort in IDLE or CLEAR is ignored.
  - abort has priority over a simultaneous proc_done, a final load beat or a final output beat.
- Ignored inputs: in_valid outside LOAD; proc_done outside PROC; out_ready outside OUT.
- Asynchronous reset mid-tile forces every register to its reset value immediately, with no tile_clear pulse. Operation resumes with IDLE->LOAD on the cycle after deassertion.
- All outputs except load_end and out_last are registered or decoded only from state.
- Latencies:
  - Last load beat -> proc_start: 1 cycle.
  - proc_done -> first readable: 1 cycle.
  - Final output beat -> tile_clear: 1 cycle.
  - tile_clear -> in_ready: 1 cycle.

Test Plan:
- Nominal tile:
  - Stimulus: reset, then 80 consecutive in_valid beats; proc_done 5 cycles after proc_start; out_ready held 1.
  - Expected: load_end rises on beat 80 (load_cnt=79); proc_start is 1 cycle after that beat; 324 readable cycles with addr 0..323; out_last at addr 323 (row 17, col 17); tile_clear pulse follows; tile_cnt=1.
- Input gaps:
  - Stimulus: drop in_valid every 3rd cycle.
  - Expected: exactly 80 beats accepted; proc_start only after the 80th accepted beat.
- Output backpressure:
  - Stimulus: out_ready=0 for 4 cycles at addr 17.
  - Expected: row=0, col=17, addr=17 stay stable; then the next beat is row=1, col=0, addr=18.
- Back-to-back tiles:
  - Stimulus: 3 tiles.
  - Expected: tile_cnt = 1, 2, 3; in_ready returns 1 cycle after each tile_clear; load_end is 0 in LOAD before beat 80.
- Abort:
  - Stimulus: abort at addr 100 in OUT, coincident with out_ready=1.
  - Expected: CLEAR next cycle; tile_clear=1; tile_cnt unchanged; addr=0; new LOAD accepts 80 fresh beats.
- Async reset:
  - Stimulus: reset asserted mid-PROC, off a clock edge.
  - Expected: all outputs 0 immediately; no proc_start retrigger; no tile_clear; normal tile completes afterward with tile_cnt=1.
